// File: rtl/lcd8080_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lcd8080_bus_ctrl
//
// Purpose:
//   8080-series parallel LCD bus master. It sits between the ILI934x
//   command/pixel sequencer and the panel pins. It takes one request at a time
//   over a valid/ready handshake. Each request becomes one chip-select framed
//   transaction on the panel bus, which is one of:
//     - a write: one SETUP phase, then (rep+1) wr_n strobes with cs_n, dc and
//       data held. This is used for pixel fills.
//     - a register read: one SETUP phase, a single rd_n strobe, and
//       lcd_d_in captured at the end of the strobe.
//   Setup, strobe and recovery lengths are set by parameters, in clk cycles.
//
// Parameters:
//   DATA_W        bus width, 8 or 16
//   REP_W         width of the repeat count
//   SETUP_CYC     cycles of cs_n/dc/data valid before the first strobe
//   WR_PULSE_CYC  cycles wr_n held low
//   WR_RECOV_CYC  cycles wr_n held high after each write strobe
//   RD_PULSE_CYC  cycles rd_n held low
//   RD_RECOV_CYC  cycles rd_n held high after the read strobe
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   item_valid/ready      request handshake; ready is high only in IDLE
//   item_is_cmd           1 = command (dc=0), 0 = data (dc=1)
//   item_is_rd            1 = read transaction, 0 = write
//   item_data             write value
//   item_rep              extra write strobes (N gives N+1 strobes)
//   rd_valid, rd_data     one-cycle pulse plus the captured read value
//   busy                  high whenever the controller is not IDLE
//   lcd_cs_n/rd_n/wr_n/dc panel control pins, all registered
//   lcd_d_out/d_oe/d_in   split bidirectional data bus
// ---------------------------------------------------------------------------
module lcd8080_bus_ctrl #(
  parameter int DATA_W       = 8,
  parameter int REP_W        = 16,
  parameter int SETUP_CYC    = 1,
  parameter int WR_PULSE_CYC = 2,
  parameter int WR_RECOV_CYC = 1,
  parameter int RD_PULSE_CYC = 4,
  parameter int RD_RECOV_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              item_valid,
  output logic              item_ready,
  input  logic              item_is_cmd,
  input  logic              item_is_rd,
  input  logic [DATA_W-1:0] item_data,
  input  logic [REP_W-1:0]  item_rep,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              lcd_cs_n,
  output logic              lcd_rd_n,
  output logic              lcd_wr_n,
  output logic              lcd_dc,
  output logic [DATA_W-1:0] lcd_d_out,
  output logic              lcd_d_oe,
  input  logic [DATA_W-1:0] lcd_d_in
);

  // Parameter legality is checked at elaboration, so a bad configuration
  // never reaches synthesis.
  if (DATA_W != 8 && DATA_W != 16) begin : g_bad_data_w
    $error("lcd8080_bus_ctrl: DATA_W must be 8 or 16");
  end
  if (SETUP_CYC < 1 || WR_PULSE_CYC < 1 || WR_RECOV_CYC < 1 ||
      RD_PULSE_CYC < 1 || RD_RECOV_CYC < 1) begin : g_bad_timing
    $error("lcd8080_bus_ctrl: all timing parameters must be >= 1");
  end
  if (REP_W < 1) begin : g_bad_rep_w
    $error("lcd8080_bus_ctrl: REP_W must be >= 1");
  end

  // One shared phase counter times every state. It has to hold the longest
  // phase length minus one.
  localparam int MAX_AB  = (SETUP_CYC > WR_PULSE_CYC) ? SETUP_CYC : WR_PULSE_CYC;
  localparam int MAX_CD  = (WR_RECOV_CYC > RD_PULSE_CYC) ? WR_RECOV_CYC : RD_PULSE_CYC;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_ABCD > RD_RECOV_CYC) ? MAX_ABCD : RD_RECOV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LO_LAST = CNT_W'(WR_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] WR_HI_LAST = CNT_W'(WR_RECOV_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LO_LAST = CNT_W'(RD_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_HI_LAST = CNT_W'(RD_RECOV_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic                is_rd_q, is_rd_d;
  logic                cs_n_q, cs_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic                dc_q, dc_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic                d_oe_q, d_oe_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                phase_done;

  // True on the last cycle of the current timed phase.
  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      S_SETUP: phase_done = (cnt_q == SETUP_LAST);
      S_WR_LO: phase_done = (cnt_q == WR_LO_LAST);
      S_WR_HI: phase_done = (cnt_q == WR_HI_LAST);
      S_RD_LO: phase_done = (cnt_q == RD_LO_LAST);
      S_RD_HI: phase_done = (cnt_q == RD_HI_LAST);
      default: phase_done = 1'b0;
    endcase
  end

  // Next-state logic. Pin values are derived from the next state, so each
  // registered pin changes on the same edge where the state register enters
  // the state that owns that pin value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    is_rd_d    = is_rd_q;
    dc_d       = dc_q;
    d_out_d    = d_out_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = phase_done ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (item_valid) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          is_rd_d = item_is_rd;
          dc_d    = ~item_is_cmd;
          rep_d   = item_is_rd ? '0 : item_rep;
          // On a read, d_out keeps its old value because the bus is not driven.
          if (!item_is_rd) begin
            d_out_d = item_data;
          end
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          state_d = is_rd_q ? S_RD_LO : S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (phase_done) begin
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        // The repeat counter is tested before it is decremented, so an
        // all-ones count gives exactly 2^REP_W strobes and never wraps.
        if (phase_done) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - REP_W'(1);
            state_d = S_WR_LO;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RD_LO: begin
        if (phase_done) begin
          state_d    = S_RD_HI;
          rd_data_d  = lcd_d_in;
          rd_valid_d = 1'b1;
        end
      end
      S_RD_HI: begin
        if (phase_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cs_n_d = (state_d == S_IDLE);
    wr_n_d = (state_d != S_WR_LO);
    rd_n_d = (state_d != S_RD_LO);
    d_oe_d = ((state_d == S_SETUP) && !is_rd_d) ||
             (state_d == S_WR_LO) || (state_d == S_WR_HI);
  end

  // State, counters and all pin registers. Reset abandons any burst that is
  // in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rep_q      <= '0;
      is_rd_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      dc_q       <= 1'b1;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      is_rd_q    <= is_rd_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      dc_q       <= dc_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign item_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign lcd_cs_n   = cs_n_q;
  assign lcd_rd_n   = rd_n_q;
  assign lcd_wr_n   = wr_n_q;
  assign lcd_dc     = dc_q;
  assign lcd_d_out  = d_out_q;
  assign lcd_d_oe   = d_oe_q;

endmodule

// File: tb/tb_lcd8080_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd8080_bus_ctrl
//
// Two instances share one clock and one reset:
//   u_dut_a : DATA_W=8,  REP_W=4  (command writes, reads, back-to-back items,
//             mid-burst reset and the all-ones repeat count)
//   u_dut_b : DATA_W=16, REP_W=16 (16-bit pixel burst)
// Tasks queue the expected write strobes and read values when they drive
// stimulus. The monitor threads pop and compare these entries when the DUT
// shows a wr_n fall or an rd_valid pulse. Each test task also checks the
// per-cycle pin timing inline.
// ---------------------------------------------------------------------------
module tb_lcd8080_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Free-running 100 MHz style clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  logic       a_valid = 1'b0, a_ready, a_is_cmd = 1'b0, a_is_rd = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic [3:0] a_rep = 4'h0;
  logic       a_rd_valid, a_busy, a_cs_n, a_rd_n, a_wr_n, a_dc, a_d_oe;
  logic [7:0] a_rd_data, a_d_out;
  logic [7:0] a_d_in = 8'h00;

  logic        b_valid = 1'b0, b_ready, b_is_cmd = 1'b0, b_is_rd = 1'b0;
  logic [15:0] b_data = 16'h0000;
  logic [15:0] b_rep = 16'h0000;
  logic        b_rd_valid, b_busy, b_cs_n, b_rd_n, b_wr_n, b_dc, b_d_oe;
  logic [15:0] b_rd_data, b_d_out;
  logic [15:0] b_d_in = 16'h0000;

  lcd8080_bus_ctrl #(.DATA_W(8), .REP_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .item_valid(a_valid), .item_ready(a_ready),
    .item_is_cmd(a_is_cmd), .item_is_rd(a_is_rd),
    .item_data(a_data), .item_rep(a_rep),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .busy(a_busy),
    .lcd_cs_n(a_cs_n), .lcd_rd_n(a_rd_n), .lcd_wr_n(a_wr_n), .lcd_dc(a_dc),
    .lcd_d_out(a_d_out), .lcd_d_oe(a_d_oe), .lcd_d_in(a_d_in)
  );

  lcd8080_bus_ctrl #(.DATA_W(16), .REP_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .item_valid(b_valid), .item_ready(b_ready),
    .item_is_cmd(b_is_cmd), .item_is_rd(b_is_rd),
    .item_data(b_data), .item_rep(b_rep),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .busy(b_busy),
    .lcd_cs_n(b_cs_n), .lcd_rd_n(b_rd_n), .lcd_wr_n(b_wr_n), .lcd_dc(b_dc),
    .lcd_d_out(b_d_out), .lcd_d_oe(b_d_oe), .lcd_d_in(b_d_in)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboards: write entries are {dc, data16}, read entries are data16.
  logic [16:0] a_wr_exp[$];
  logic [16:0] b_wr_exp[$];
  logic [15:0] a_rd_exp[$];
  int a_strobes = 0;
  int b_strobes = 0;

  // Timing of the defaults, used to build the expected burst numbers.
  localparam int SETUP = 1;
  localparam int WRP   = 2;
  localparam int WRR   = 1;

  // Monitor for DUT A. On every wr_n fall it checks the next queued strobe,
  // and requires cs_n low and the bus driven. On every rd_valid pulse it
  // checks the next queued read value.
  task automatic monitor_a();
    logic        prev_wr;
    logic [16:0] e;
    logic [15:0] r;
    prev_wr = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_wr && !a_wr_n) begin
        a_strobes++;
        tests_run++;
        if (a_wr_exp.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL a_strobe_unexpected: got dc=%0b d=%h, required no strobe", a_dc, a_d_out);
        end else begin
          e = a_wr_exp.pop_front();
          if ({a_cs_n, a_d_oe, a_dc, 8'h00, a_d_out} !== {1'b0, 1'b1, e}) begin
            tests_failed++;
            $display("[TB] FAIL a_strobe: got cs_n/oe/dc/d=%b/%b/%b/%h, required 0/1/%b/%h",
                     a_cs_n, a_d_oe, a_dc, a_d_out, e[16], e[7:0]);
          end
        end
      end
      if (a_rd_valid) begin
        tests_run++;
        if (a_rd_exp.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL a_rd_unexpected: got rd_valid with data %h, required none", a_rd_data);
        end else begin
          r = a_rd_exp.pop_front();
          if ({8'h00, a_rd_data} !== r) begin
            tests_failed++;
            $display("[TB] FAIL a_rd_data: got %h, required %h", a_rd_data, r[7:0]);
          end
        end
      end
      prev_wr = a_wr_n;
    end
  endtask

  // Monitor for DUT B. It only ever performs writes, so any rd_valid is wrong.
  task automatic monitor_b();
    logic        prev_wr;
    logic [16:0] e;
    prev_wr = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_wr && !b_wr_n) begin
        b_strobes++;
        tests_run++;
        if (b_wr_exp.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL b_strobe_unexpected: got dc=%0b d=%h, required no strobe", b_dc, b_d_out);
        end else begin
          e = b_wr_exp.pop_front();
          if ({b_cs_n, b_d_oe, b_dc, b_d_out} !== {1'b0, 1'b1, e}) begin
            tests_failed++;
            $display("[TB] FAIL b_strobe: got cs_n/oe/dc/d=%b/%b/%b/%h, required 0/1/%b/%h",
                     b_cs_n, b_d_oe, b_dc, b_d_out, e[16], e[15:0]);
          end
        end
      end
      if (b_rd_valid) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL b_rd_unexpected: got rd_valid, required none");
      end
      prev_wr = b_wr_n;
    end
  endtask

  // Present one item to DUT A for a single cycle. The caller is #1 past a
  // posedge with the DUT idle. The task returns #1 into the first SETUP cycle.
  task automatic apply_stimulus_a(input logic is_cmd, input logic is_rd,
                                  input logic [7:0] data, input logic [3:0] rep);
    a_valid  = 1'b1;
    a_is_cmd = is_cmd;
    a_is_rd  = is_rd;
    a_data   = data;
    a_rep    = rep;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  // Same as apply_stimulus_a, for the 16-bit instance.
  task automatic apply_stimulus_b(input logic is_cmd, input logic is_rd,
                                  input logic [15:0] data, input logic [15:0] rep);
    b_valid  = 1'b1;
    b_is_cmd = is_cmd;
    b_is_rd  = is_rd;
    b_data   = data;
    b_rep    = rep;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  // Hold reset over a few edges, then check every output of both instances.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({a_cs_n, a_wr_n, a_rd_n, a_dc, a_d_oe, a_rd_valid, a_busy, a_ready} !== 8'b1111_0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_a_ctrl: got %b, required 11110001",
               {a_cs_n, a_wr_n, a_rd_n, a_dc, a_d_oe, a_rd_valid, a_busy, a_ready});
    end
    tests_run++;
    if ({a_d_out, a_rd_data} !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_a_data: got d_out=%h rd_data=%h, required 00/00", a_d_out, a_rd_data);
    end
    tests_run++;
    if ({b_cs_n, b_wr_n, b_rd_n, b_dc, b_d_oe, b_rd_valid, b_busy, b_ready} !== 8'b1111_0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_b_ctrl: got %b, required 11110001",
               {b_cs_n, b_wr_n, b_rd_n, b_dc, b_d_oe, b_rd_valid, b_busy, b_ready});
    end
    tests_run++;
    if ({b_d_out, b_rd_data} !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_b_data: got d_out=%h rd_data=%h, required 0000/0000", b_d_out, b_rd_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single command write 0x2C, rep=0: check cycle-exact timing T1..T5.
  task automatic test_write_cmd();
    logic [3:0] exp_v [5];
    exp_v = '{4'b0110, 4'b0010, 4'b0010, 4'b0110, 4'b1101}; // {cs_n,wr_n,oe,ready}
    @(posedge clk);
    #1;
    a_wr_exp.push_back({1'b0, 16'h002C});
    apply_stimulus_a(1'b1, 1'b0, 8'h2C, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if ({a_cs_n, a_wr_n, a_d_oe, a_ready} !== exp_v[k]) begin
        tests_failed++;
        $display("[TB] FAIL wr_cmd_T%0d: got cs_n/wr_n/oe/ready=%b, required %b",
                 k + 1, {a_cs_n, a_wr_n, a_d_oe, a_ready}, exp_v[k]);
      end
      tests_run++;
      if (a_d_out !== 8'h2C || (k < 4 && a_dc !== 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL wr_cmd_bus_T%0d: got d_out=%h dc=%b, required 2c dc=0", k + 1, a_d_out, a_dc);
      end
    end
  endtask

  // 16-bit data burst 0xF800, rep=3: four strobes in one chip-select frame.
  task automatic test_write_burst16();
    int   cs_low, falls, first_fall, end_cyc, bad_hold;
    logic prev;
    cs_low = 0; falls = 0; first_fall = 0; end_cyc = 0; bad_hold = 0; prev = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) b_wr_exp.push_back({1'b1, 16'hF800});
    apply_stimulus_b(1'b0, 1'b0, 16'hF800, 16'd3);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!b_cs_n) begin
        cs_low++;
        if (b_d_out !== 16'hF800 || b_dc !== 1'b1 || b_d_oe !== 1'b1) bad_hold++;
      end else if (cs_low > 0 && end_cyc == 0) begin
        end_cyc = k;
      end
      if (prev && !b_wr_n) begin
        falls++;
        if (first_fall == 0) first_fall = k;
      end
      prev = b_wr_n;
    end
    tests_run++;
    if (cs_low !== SETUP + 4 * (WRP + WRR)) begin
      tests_failed++;
      $display("[TB] FAIL burst16_cs_low: got %0d cycles, required %0d", cs_low, SETUP + 4 * (WRP + WRR));
    end
    tests_run++;
    if (end_cyc !== 1 + SETUP + 4 * (WRP + WRR)) begin
      tests_failed++;
      $display("[TB] FAIL burst16_cs_end: got cycle %0d, required %0d", end_cyc, 1 + SETUP + 4 * (WRP + WRR));
    end
    tests_run++;
    if (falls !== 4) begin
      tests_failed++;
      $display("[TB] FAIL burst16_strobes: got %0d, required 4", falls);
    end
    tests_run++;
    if (first_fall !== 1 + SETUP) begin
      tests_failed++;
      $display("[TB] FAIL burst16_first_fall: got T%0d, required T%0d", first_fall, 1 + SETUP);
    end
    tests_run++;
    if (bad_hold !== 0) begin
      tests_failed++;
      $display("[TB] FAIL burst16_hold: got %0d bad cycles, required 0", bad_hold);
    end
  endtask

  // Register read: lcd_d_in shows 0x93 only during the last RD_LO cycle.
  task automatic test_read();
    logic [4:0] exp_v [8];
    // {cs_n, rd_n, wr_n, oe, rd_valid} for T1..T8
    exp_v = '{5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100,
              5'b01101, 5'b01100, 5'b11100};
    @(posedge clk);
    #1;
    a_rd_exp.push_back(16'h0093);
    a_d_in = 8'h00;
    apply_stimulus_a(1'b1, 1'b1, 8'hFF, 4'h7);
    for (int k = 0; k < 8; k++) begin
      a_d_in = (k == 4) ? 8'h93 : 8'h00;
      @(negedge clk);
      tests_run++;
      if ({a_cs_n, a_rd_n, a_wr_n, a_d_oe, a_rd_valid} !== exp_v[k]) begin
        tests_failed++;
        $display("[TB] FAIL read_T%0d: got cs_n/rd_n/wr_n/oe/rd_valid=%b, required %b",
                 k + 1, {a_cs_n, a_rd_n, a_wr_n, a_d_oe, a_rd_valid}, exp_v[k]);
      end
      if (k >= 5) begin
        tests_run++;
        if (a_rd_data !== 8'h93) begin
          tests_failed++;
          $display("[TB] FAIL read_hold_T%0d: got %h, required 93", k + 1, a_rd_data);
        end
      end
      @(posedge clk);
      #1;
    end
    a_d_in = 8'h00;
  endtask

  // Two writes with item_valid held high. item_data changes while busy must
  // not reach the bus, and the second accept happens in the IDLE cycle.
  task automatic test_back_to_back();
    logic [2:0] exp_v [10];
    logic [7:0] exp_d [10];
    // {cs_n, wr_n, ready}
    exp_v = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b111,
              3'b010, 3'b000, 3'b000, 3'b010, 3'b111};
    exp_d = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11,
              8'h29, 8'h29, 8'h29, 8'h29, 8'h29};
    @(posedge clk);
    #1;
    a_wr_exp.push_back({1'b1, 16'h0011});
    a_wr_exp.push_back({1'b1, 16'h0029});
    a_valid = 1'b1; a_is_cmd = 1'b0; a_is_rd = 1'b0; a_data = 8'h11; a_rep = 4'h0;
    @(posedge clk);
    #1;
    a_data = 8'h29;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if ({a_cs_n, a_wr_n, a_ready} !== exp_v[k] || a_d_out !== exp_d[k]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_T%0d: got cs_n/wr_n/ready=%b d_out=%h, required %b %h",
                 k + 1, {a_cs_n, a_wr_n, a_ready}, a_d_out, exp_v[k], exp_d[k]);
      end
      @(posedge clk);
      #1;
      if (k == 4) a_valid = 1'b0;
    end
  endtask

  // Reset on the second wr_n-low cycle of a rep=10 burst. The next item must
  // start cleanly with no leftover strobes.
  task automatic test_reset_mid_burst();
    int         s0;
    logic [3:0] exp_v [5];
    exp_v = '{4'b0110, 4'b0010, 4'b0010, 4'b0110, 4'b1101}; // {cs_n,wr_n,oe,ready}
    s0 = a_strobes;
    @(posedge clk);
    #1;
    a_wr_exp.push_back({1'b1, 16'h00A5});
    apply_stimulus_a(1'b0, 1'b0, 8'hA5, 4'd10);   // now in T1
    @(posedge clk);
    #1;                                           // T2, first wr_n low
    @(posedge clk);
    #1;                                           // T3, second wr_n low
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if ({a_cs_n, a_wr_n, a_rd_n, a_dc, a_d_oe, a_rd_valid, a_busy, a_ready} !== 8'b1111_0001) begin
      tests_failed++;
      $display("[TB] FAIL midrst_ctrl: got %b, required 11110001",
               {a_cs_n, a_wr_n, a_rd_n, a_dc, a_d_oe, a_rd_valid, a_busy, a_ready});
    end
    tests_run++;
    if ({a_d_out, a_rd_data} !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL midrst_data: got d_out=%h rd_data=%h, required 00/00", a_d_out, a_rd_data);
    end
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    a_wr_exp.push_back({1'b0, 16'h003C});
    apply_stimulus_a(1'b1, 1'b0, 8'h3C, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if ({a_cs_n, a_wr_n, a_d_oe, a_ready} !== exp_v[k] || a_d_out !== 8'h3C) begin
        tests_failed++;
        $display("[TB] FAIL midrst_new_T%0d: got cs_n/wr_n/oe/ready=%b d_out=%h, required %b 3c",
                 k + 1, {a_cs_n, a_wr_n, a_d_oe, a_ready}, a_d_out, exp_v[k]);
      end
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (a_strobes - s0 !== 2) begin
      tests_failed++;
      $display("[TB] FAIL midrst_strobes: got %0d, required 2", a_strobes - s0);
    end
  endtask

  // REP_W=4 with rep=4'hF: exactly 16 strobes, then IDLE.
  task automatic test_rep_max();
    int s0, done_k;
    s0 = a_strobes;
    done_k = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) a_wr_exp.push_back({1'b1, 16'h005A});
    apply_stimulus_a(1'b0, 1'b0, 8'h5A, 4'hF);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (a_ready && done_k == 0) done_k = k;
    end
    tests_run++;
    if (done_k !== 1 + SETUP + 16 * (WRP + WRR)) begin
      tests_failed++;
      $display("[TB] FAIL repmax_ready: got T%0d, required T%0d", done_k, 1 + SETUP + 16 * (WRP + WRR));
    end
    tests_run++;
    if (a_strobes - s0 !== 16) begin
      tests_failed++;
      $display("[TB] FAIL repmax_strobes: got %0d, required 16", a_strobes - s0);
    end
  endtask

  // Every queued expectation must have been consumed by the monitors.
  task automatic test_drain();
    repeat (5) @(negedge clk);
    tests_run++;
    if (a_wr_exp.size() + b_wr_exp.size() + a_rd_exp.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got %0d/%0d/%0d leftover entries, required 0/0/0",
               a_wr_exp.size(), b_wr_exp.size(), a_rd_exp.size());
    end
  endtask

  // Main sequence. The monitors run as forked threads of this same block.
  initial begin
    fork
      monitor_a();
      monitor_b();
    join_none
    test_reset();
    test_write_cmd();
    test_write_burst16();
    test_read();
    test_back_to_back();
    test_reset_mid_burst();
    test_rep_max();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
